// File: rtl/ev22_data_mem_responder.sv
// EV22 data-memory responder: single-cycle writes, fixed-latency reads with busy stall.
// Optional build macro EV22_MEM_STATS_EN adds saturating rd_count/wr_count outputs.
module ev22_data_mem_responder #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MR,
    input  logic              MW,
    input  logic [ADDR_W-1:0] Mem_Addr,
    input  logic [15:0]       W_MEM_OUT,
    output logic [15:0]       W_MEM_IN,
    output logic              rd_valid,
    output logic              mem_busy,
    output logic              collision
`ifdef EV22_MEM_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_read_lat
        $error("ev22_data_mem_responder: READ_LAT must be in 1..4");
    end
    if (DEPTH == 0 || 64'(DEPTH) > (64'd1 << ADDR_W)) begin : g_bad_depth
        $error("ev22_data_mem_responder: DEPTH must be 1..2^ADDR_W");
    end

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    addr_q, addr_d;
    logic                rng_q, rng_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rd_valid_q, rd_valid_d;
    logic                busy_q, busy_d;
    logic                coll_q, coll_d;
    logic                wr_en;
    logic                in_range;
    logic [DATA_W-1:0]   rd_word;

    logic [DATA_W-1:0]   mem [DEPTH];

    assign in_range = (32'(Mem_Addr) < DEPTH);
    assign rd_word  = rng_q ? mem[addr_q] : '0;

    // Array carries no reset so its contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[IDX_W'(Mem_Addr)] <= W_MEM_OUT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (MR && !MW) state_d = RD_WAIT;
            RD_WAIT: if (cnt_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Requests are only honoured in IDLE; a simultaneous MR+MW keeps the write.
    always_comb begin
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        rng_d      = rng_q;
        rdata_d    = rdata_q;
        rd_valid_d = 1'b0;
        busy_d     = busy_q;
        coll_d     = coll_q;
        wr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (MW) begin
                    wr_en = in_range;
                    if (MR) coll_d = 1'b1;
                end else if (MR) begin
                    addr_d = IDX_W'(Mem_Addr);
                    rng_d  = in_range;
                    cnt_d  = CNT_W'(READ_LAT - 1);
                    busy_d = 1'b1;
                end
            end
            RD_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = CNT_W'(cnt_q - 1'b1);
                end else begin
                    rdata_d    = rd_word;
                    rd_valid_d = 1'b1;
                    busy_d     = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            addr_q     <= '0;
            rng_q      <= 1'b0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            coll_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            rng_q      <= rng_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
            coll_q     <= coll_d;
        end
    end

    assign W_MEM_IN  = rdata_q;
    assign rd_valid  = rd_valid_q;
    assign mem_busy  = busy_q;
    assign collision = coll_q;

`ifdef EV22_MEM_STATS_EN
    logic [15:0] rd_cnt_q, wr_cnt_q;
    logic        wr_acc;
    logic        rd_done;

    assign wr_acc  = (state_q == IDLE) && MW;
    assign rd_done = (state_q == RD_WAIT) && (cnt_q == '0);

    // Saturating request statistics; out-of-range writes still count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (rd_done && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
            if (wr_acc && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_ev22_data_mem_responder.sv
// Bench for ev22_data_mem_responder: three configurations share one stimulus stream
// and are checked every cycle against an edge-counting reference model.
module tb_ev22_data_mem_responder;

    localparam int NI = 3;

    logic        clk;
    logic        reset;
    logic        MR;
    logic        MW;
    logic [7:0]  Mem_Addr;
    logic [15:0] W_MEM_OUT;

    logic [15:0] rdata [NI];
    logic        rv    [NI];
    logic        bz    [NI];
    logic        co    [NI];
`ifdef EV22_MEM_STATS_EN
    logic [15:0] rdc   [NI];
    logic [15:0] wrc   [NI];
`endif

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state (per instance)
    int          m_lat   [NI] = '{1, 3, 4};
    int          m_depth [NI] = '{256, 200, 256};
    logic [15:0] m_mem   [NI][256];
    logic [15:0] m_out   [NI];
    bit          m_valid [NI];
    bit          m_busy  [NI];
    bit          m_coll  [NI];
    int          m_done  [NI];
    int          m_addr  [NI];
    int          m_rdc   [NI];
    int          m_wrc   [NI];
    int          edge_n = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ev22_data_mem_responder u_a (
        .clk(clk), .reset(reset), .MR(MR), .MW(MW), .Mem_Addr(Mem_Addr), .W_MEM_OUT(W_MEM_OUT),
        .W_MEM_IN(rdata[0]), .rd_valid(rv[0]), .mem_busy(bz[0]), .collision(co[0])
`ifdef EV22_MEM_STATS_EN
        , .rd_count(rdc[0]), .wr_count(wrc[0])
`endif
    );

    ev22_data_mem_responder #(.ADDR_W(8), .DEPTH(200), .READ_LAT(3)) u_b (
        .clk(clk), .reset(reset), .MR(MR), .MW(MW), .Mem_Addr(Mem_Addr), .W_MEM_OUT(W_MEM_OUT),
        .W_MEM_IN(rdata[1]), .rd_valid(rv[1]), .mem_busy(bz[1]), .collision(co[1])
`ifdef EV22_MEM_STATS_EN
        , .rd_count(rdc[1]), .wr_count(wrc[1])
`endif
    );

    ev22_data_mem_responder #(.ADDR_W(8), .DEPTH(256), .READ_LAT(4)) u_c (
        .clk(clk), .reset(reset), .MR(MR), .MW(MW), .Mem_Addr(Mem_Addr), .W_MEM_OUT(W_MEM_OUT),
        .W_MEM_IN(rdata[2]), .rd_valid(rv[2]), .mem_busy(bz[2]), .collision(co[2])
`ifdef EV22_MEM_STATS_EN
        , .rd_count(rdc[2]), .wr_count(wrc[2])
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_out[i]   = 16'h0000;
            m_valid[i] = 1'b0;
            m_busy[i]  = 1'b0;
            m_coll[i]  = 1'b0;
            m_rdc[i]   = 0;
            m_wrc[i]   = 0;
        end
    endtask

    // A read accepted at edge n delivers its data at edge n+latency.
    task automatic model_edge(input bit mr, input bit mw, input int addr, input logic [15:0] d);
        edge_n++;
        for (int i = 0; i < NI; i++) begin
            m_valid[i] = 1'b0;
            if (m_busy[i]) begin
                if (edge_n == m_done[i]) begin
                    m_out[i]   = (m_addr[i] < m_depth[i]) ? m_mem[i][m_addr[i]] : 16'h0000;
                    m_valid[i] = 1'b1;
                    m_busy[i]  = 1'b0;
                    if (m_rdc[i] < 65535) m_rdc[i]++;
                end
            end else if (mw) begin
                if (addr < m_depth[i]) m_mem[i][addr] = d;
                if (m_wrc[i] < 65535) m_wrc[i]++;
                if (mr) m_coll[i] = 1'b1;
            end else if (mr) begin
                m_busy[i] = 1'b1;
                m_done[i] = edge_n + m_lat[i];
                m_addr[i] = addr;
            end
        end
    endtask

    task automatic check_all(input string ph);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s u%0d W_MEM_IN", ph, i), rdata[i], m_out[i]);
            chk($sformatf("%s u%0d rd_valid", ph, i), 16'(rv[i]), 16'(m_valid[i]));
            chk($sformatf("%s u%0d mem_busy", ph, i), 16'(bz[i]), 16'(m_busy[i]));
            chk($sformatf("%s u%0d collision", ph, i), 16'(co[i]), 16'(m_coll[i]));
`ifdef EV22_MEM_STATS_EN
            chk($sformatf("%s u%0d rd_count", ph, i), rdc[i], 16'(m_rdc[i]));
            chk($sformatf("%s u%0d wr_count", ph, i), wrc[i], 16'(m_wrc[i]));
`endif
        end
    endtask

    task automatic cycle(input string ph, input bit mr, input bit mw, input int addr, input logic [15:0] d);
        MR        = mr;
        MW        = mw;
        Mem_Addr  = 8'(addr);
        W_MEM_OUT = d;
        @(posedge clk);
        model_edge(mr, mw, addr, d);
        #1;
        check_all(ph);
    endtask

    task automatic idle(input string ph, input int n);
        for (int k = 0; k < n; k++) cycle(ph, 1'b0, 1'b0, 0, 16'h0000);
    endtask

    initial begin
        reset     = 1'b1;
        MR        = 1'b0;
        MW        = 1'b0;
        Mem_Addr  = 8'h00;
        W_MEM_OUT = 16'h0000;
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // Give every word a known value.
        for (int a = 0; a < 256; a++) cycle("preload", 1'b0, 1'b1, a, 16'(a * 257) ^ 16'h5A5A);

        // Write then read back 0x05.
        cycle("wr05", 1'b0, 1'b1, 8'h05, 16'hBEEF);
        cycle("rd05", 1'b1, 1'b0, 8'h05, 16'h0000);
        chk("dir busy_a after MR", 16'(bz[0]), 16'd1);
        cycle("rd05_w", 1'b0, 1'b0, 0, 16'h0000);
        chk("dir rd_valid_a", 16'(rv[0]), 16'd1);
        chk("dir data_a", rdata[0], 16'hBEEF);
        chk("dir busy_a released", 16'(bz[0]), 16'd0);
        cycle("rd05_w", 1'b0, 1'b0, 0, 16'h0000);
        cycle("rd05_w", 1'b0, 1'b0, 0, 16'h0000);
        chk("dir rd_valid_b lat3", 16'(rv[1]), 16'd1);
        chk("dir data_b", rdata[1], 16'hBEEF);
        idle("rd05_idle", 3);

        // Writes issued while busy (and at the release edge) are dropped.
        cycle("wr10", 1'b0, 1'b1, 8'h10, 16'h1234);
        cycle("rd10", 1'b1, 1'b0, 8'h10, 16'h0000);
        cycle("wr10_busy", 1'b0, 1'b1, 8'h10, 16'hFFFF);
        cycle("wr10_busy", 1'b0, 1'b1, 8'h10, 16'hEEEE);
        idle("rd10_w", 4);
        cycle("rd10b", 1'b1, 1'b0, 8'h10, 16'h0000);
        idle("rd10b_w", 5);
        chk("dir data_c keeps 1234", rdata[2], 16'h1234);

        // Collision: write wins, flag sticks.
        cycle("coll", 1'b1, 1'b1, 8'h20, 16'hA5A5);
        chk("dir collision_a", 16'(co[0]), 16'd1);
        idle("coll_w", 2);
        cycle("rd20", 1'b1, 1'b0, 8'h20, 16'h0000);
        idle("rd20_w", 5);

        // Out of range on the DEPTH=200 instance.
        cycle("wrF0", 1'b0, 1'b1, 8'hF0, 16'h7777);
        cycle("rdF0", 1'b1, 1'b0, 8'hF0, 16'h0000);
        idle("rdF0_w", 5);
        chk("dir oob data_b", rdata[1], 16'h0000);
        cycle("rd00", 1'b1, 1'b0, 8'h00, 16'h0000);
        idle("rd00_w", 5);

        // Asynchronous reset in the middle of the latency-4 read.
        cycle("wr33", 1'b0, 1'b1, 8'h33, 16'hC0DE);
        cycle("rd33", 1'b1, 1'b0, 8'h33, 16'h0000);
        cycle("rd33_w", 1'b0, 1'b0, 0, 16'h0000);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("rst_mid");
        chk("dir busy_c cleared by reset", 16'(bz[2]), 16'd0);
        @(negedge clk);
        reset = 1'b0;
        idle("post_rst", 4);
        cycle("rd33b", 1'b1, 1'b0, 8'h33, 16'h0000);
        idle("rd33b_w", 5);
        chk("dir retained data_c", rdata[2], 16'hC0DE);

        // Randomised traffic.
        for (int k = 0; k < 600; k++) begin
            int  r;
            int  addr;
            bit  mr;
            bit  mw;
            r    = int'($urandom_range(0, 19));
            mr   = (r < 6) || (r == 19);
            mw   = (r >= 12);
            addr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(190, 255))
                                               : int'($urandom_range(0, 15));
            cycle("rand", mr, mw, addr, 16'($urandom));
        end
        idle("drain", 6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ev22_data_mem_responder.md
Name: ev22_data_mem_responder

Overview:
- Data-memory responder on the EV22 CPU memory interface. It services the MR/MW requests issued by the register-bank side.
- MW: stores the working-register value at Mem_Addr. MR: returns the stored word on W_MEM_IN, which the register bank latches into W when Sel_C = 34 and MR = 1.
- Read latency is parameterised. The block raises mem_busy so the control unit can stall while a read is in flight.

Parameters:
- ADDR_W, 8, address width in bits.
- DEPTH, 256, number of 16-bit words; must be ≤ 2^ADDR_W.
- READ_LAT, 1, cycles from the MR sampling edge to read-data valid. Legal range is 1..4; any other value is an elaboration error.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- MR  input  1  memory read request, sampled at posedge clk.
- MW  input  1  memory write request, sampled at posedge clk.
- Mem_Addr  input  ADDR_W  word address of the request.
- W_MEM_OUT  input  16  write data (working register contents).
- W_MEM_IN  output  16  read data returned to the register bank.
- rd_valid  output  1  one-cycle pulse: W_MEM_IN has just been updated.
- mem_busy  output  1  read in flight; new requests are ignored while high.
- collision  output  1  sticky flag: MR and MW were sampled high together.

Behaviour:
- Reset is asynchronous, active-high, and takes effect immediately.
  - Outputs: W_MEM_IN = 0, rd_valid = 0, mem_busy = 0, collision = 0.
  - FSM goes to IDLE and the wait counter goes to 0.
  - The memory array is NOT cleared; contents survive reset.
- FSM states: IDLE, RD_WAIT.
- IDLE, MW = 1 at edge E:
  - mem[Mem_Addr] <= W_MEM_OUT at E. Single-cycle; mem_busy stays 0.
  - The state stays IDLE.
- IDLE, MR = 1, MW = 0 at edge E:
  - Latch Mem_Addr, set mem_busy = 1 at E, load counter = READ_LAT-1, go to RD_WAIT.
- RD_WAIT:
  - While counter ≠ 0, decrement the counter at each edge.
  - At the edge where the counter = 0, i.e. edge E+READ_LAT:
    - W_MEM_IN <= mem[latched addr].
    - rd_valid = 1 for exactly one cycle.
    - mem_busy <= 0.
    - Return to IDLE.
  - Net result: data is valid READ_LAT cycles after the MR sampling edge.
- MR and MW both high in IDLE:
  - The write is performed and the read is dropped.
  - collision is set and stays 1 until reset.
- Requests while busy: MR/MW sampled during RD_WAIT are ignored entirely (no write, no queuing). The CPU must hold its request or stall on mem_busy.
- Request at the release edge:
  - MR/MW high at the edge where mem_busy falls is also ignored.
  - The first accepted request is at the following edge.
- W_MEM_IN holds its value until the next read completes; writes never change it.
- Read-after-write:
  - A write at edge E followed by MR sampled at E+1 to the same address returns the new data.
  - There is no same-edge bypass; MR+MW together is the collision case.
- Out-of-range address (Mem_Addr ≥ DEPTH): writes are dropped, reads return 0x0000 with normal timing.
- Reset while busy: the in-flight read is aborted, rd_valid never pulses, and W_MEM_IN = 0.
- The array is inferred as synchronous RAM with no reset on the array.

Optional Feature:
- Macro: EV22_MEM_STATS_EN.
- Defined:
  - Adds outputs rd_count[15:0] and wr_count[15:0].
  - wr_count increments on each accepted write, including out-of-range writes.
  - rd_count increments on each rd_valid pulse.
  - Both counters saturate at 0xFFFF and clear on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then write then read back:
  - reset pulse; MW = 1, Mem_Addr = 0x05, W_MEM_OUT = 0xBEEF for one cycle.
  - MR = 1, Mem_Addr = 0x05 for one cycle.
  - With READ_LAT = 1: rd_valid = 1 exactly one cycle after the MR edge, W_MEM_IN = 0xBEEF, mem_busy high for 1 cycle.
- Read latency with READ_LAT = 3:
  - Preload 0x1234 at 0x10; MR at edge E.
  - mem_busy = 1 from E to E+3; rd_valid pulses at E+3 with W_MEM_IN = 0x1234.
  - An MW to 0x10 at E+1 is ignored; a later read still returns 0x1234.
- Collision:
  - MR = MW = 1, Mem_Addr = 0x20, W_MEM_OUT = 0xA5A5.
  - collision = 1, no rd_valid.
  - A subsequent read of 0x20 returns 0xA5A5; collision stays 1 until reset.
- Reset mid-read:
  - READ_LAT = 4; MR at E, reset asserted between E+1 and E+2.
  - Immediately mem_busy = 0 and W_MEM_IN = 0; no rd_valid pulse.
  - After reset, reading the previously written address returns the old data (array retained).
- Out of range:
  - DEPTH = 200: MW to 0xF0 with 0x7777, then read 0xF0 → 0x0000.
  - Read 0x00 is unaffected.
- EV22_MEM_STATS_EN:
  - 3 writes and 2 reads → wr_count = 3, rd_count = 2.
  - Force wr_count to 0xFFFF, then one more write → stays 0xFFFF.
